// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the two-requester add/subtract share.
package addsub_arb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 3;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 2;

    localparam logic [DATA_W-1:0] SAT_VALUE = 16'hFFFF;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_AGU = 1'b1;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] sum;
        logic [FLAG_W-1:0] flag;
    } rsp_t;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit saturating add/subtract built from four ripple nibble stages.
module addsub_16bit
    import addsub_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] res_c,
    output logic [FLAG_W-1:0] flag_c
);

    localparam int unsigned NIB = DATA_W / 4;

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] raw;
    logic [NIB:0]      carry;
    logic              msb_cin;
    logic              ovf;

    // Overflow is the top nibble's carry into the MSB disagreeing with its carry out.
    always_comb begin
        b_eff    = sub ? ~b : b;
        raw      = '0;
        carry    = '0;
        carry[0] = sub;
        for (int i = 0; i < int'(NIB); i++) begin
            {carry[i+1], raw[4*i +: 4]} = 5'(a[4*i +: 4]) + 5'(b_eff[4*i +: 4]) + 5'(carry[i]);
        end
        msb_cin = a[DATA_W-1] ^ b_eff[DATA_W-1] ^ raw[DATA_W-1];
        ovf     = msb_cin ^ carry[NIB];
        res_c   = ovf ? SAT_VALUE : raw;
        flag_c         = '0;
        flag_c[FLAG_N] = res_c[DATA_W-1];
        flag_c[FLAG_V] = ovf;
        flag_c[FLAG_Z] = (res_c == '0);
    end

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; grant is one-hot and already qualified by free.
module rr_arbiter_2
    import addsub_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       free,
    output logic [1:0] grant_c
);

    logic last_q;

    always_comb begin
        grant_c = '0;
        if (free) begin
            if (valid[0] && (!valid[1] || last_q == REQ_AGU)) begin
                grant_c[0] = 1'b1;
            end else if (valid[1]) begin
                grant_c[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_AGU;
        end else if (|grant_c) begin
            last_q <= grant_c[1];
        end
    end

endmodule

// File: rtl/addsub_share_arb.sv
// Shares one saturating add/sub between ALU and AGU with a registered response port.
// ADDSUB_ARB_FLAGREG_EN enables the architectural flag register driven by wflag.
module addsub_share_arb
    import addsub_arb_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req0_wflag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    input  logic              req1_wflag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
    output logic [FLAG_W-1:0] rsp_flag,
    output logic [FLAG_W-1:0] flag_q,
    output logic [CNT_W-1:0]  sat_cnt
);

    logic              free_c;
    logic [1:0]        grant_c;
    logic              accept_c;
    logic              sel_c;
    logic [DATA_W-1:0] a_c;
    logic [DATA_W-1:0] b_c;
    logic              sub_c;
    logic [DATA_W-1:0] res_c;
    logic [FLAG_W-1:0] flag_c;

    rsp_t              rsp_q;
    logic              rsp_valid_q;
    logic [CNT_W-1:0]  sat_q;

    // Reset blocks new accepts so nothing is granted while rst is held.
    assign free_c = ~rst & (~rsp_valid_q | rsp_ready);

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .free    (free_c),
        .grant_c (grant_c)
    );

    assign req0_ready = grant_c[0];
    assign req1_ready = grant_c[1];
    assign accept_c   = |grant_c;
    assign sel_c      = grant_c[1];

    assign a_c   = sel_c ? req1_a   : req0_a;
    assign b_c   = sel_c ? req1_b   : req0_b;
    assign sub_c = sel_c ? req1_sub : req0_sub;

    addsub_16bit u_addsub (
        .a      (a_c),
        .b      (b_c),
        .sub    (sub_c),
        .res_c  (res_c),
        .flag_c (flag_c)
    );

    // Response register: overwritten on accept, drained by rsp_ready otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            sat_q       <= '0;
        end else begin
            if (accept_c) begin
                rsp_valid_q <= 1'b1;
                rsp_q       <= '{id: (sel_c ? REQ_AGU : REQ_ALU), sum: res_c, flag: flag_c};
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (accept_c && flag_c[FLAG_V] && !(&sat_q)) begin
                sat_q <= sat_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_flag  = rsp_q.flag;
    assign sat_cnt   = sat_q;

`ifdef ADDSUB_ARB_FLAGREG_EN
    logic              wflag_c;
    logic [FLAG_W-1:0] flag_r;

    assign wflag_c = sel_c ? req1_wflag : req0_wflag;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_r <= '0;
        end else if (accept_c && wflag_c) begin
            flag_r <= flag_c;
        end
    end

    assign flag_q = flag_r;
`else
    logic wflag_unused;
    assign wflag_unused = ^{req0_wflag, req1_wflag};
    assign flag_q       = '0;
`endif

endmodule

// File: tb/tb_addsub_share_arb.sv
// Scoreboard bench for addsub_share_arb: driver pushes expected responses, monitor pops on handshake.
module tb_addsub_share_arb;

    localparam int unsigned CNT_W   = 8;
    localparam int          SAT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit          v;
        logic [15:0] a;
        logic [15:0] b;
        bit          s;
        bit          w;
    } req_t;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic [2:0]  flag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [15:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_sub = 1'b0, req1_sub = 1'b0;
    logic             req0_wflag = 1'b0, req1_wflag = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [15:0]      rsp_sum;
    logic [2:0]       rsp_flag;
    logic [2:0]       flag_q;
    logic [CNT_W-1:0] sat_cnt;

    addsub_share_arb #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req0_wflag (req0_wflag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .req1_wflag (req1_wflag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_flag   (rsp_flag),
        .flag_q     (flag_q),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;
    bit   armed  = 1'b0;
    exp_t sb[$];

    // Reference state as the specification describes it.
    bit          m_rv   = 1'b0;
    bit          m_last = 1'b1;
    int          m_sat  = 0;
    logic [2:0]  m_flag = '0;
    exp_t        m_hold = '{id: 1'b0, sum: 16'h0, flag: 3'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Signed arithmetic with overflow forcing the all-ones result.
    function automatic exp_t model_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                                      input bit s);
        int   r;
        bit   v;
        exp_t e;
        r = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        v = (r > 32767) || (r < -32768);
        e.id   = id;
        e.sum  = v ? 16'hFFFF : 16'(r);
        e.flag = {e.sum[15], v, (e.sum == 16'h0)};
        return e;
    endfunction

    task automatic cycle(input bit r, input req_t q0, input req_t q1, input bit rr);
        bit   free, g0, g1;
        exp_t e;
        @(negedge clk);
        if (armed) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            chk("rsp_id_reg", 32'(rsp_id), 32'(m_hold.id));
            chk("rsp_sum_reg", 32'(rsp_sum), 32'(m_hold.sum));
            chk("rsp_flag_reg", 32'(rsp_flag), 32'(m_hold.flag));
            chk("sat_cnt", 32'(sat_cnt), 32'(m_sat));
            chk("flag_q", 32'(flag_q), 32'(m_flag));
        end
        rst        = r;
        req0_valid = q0.v; req0_a = q0.a; req0_b = q0.b; req0_sub = q0.s; req0_wflag = q0.w;
        req1_valid = q1.v; req1_a = q1.a; req1_b = q1.b; req1_sub = q1.s; req1_wflag = q1.w;
        rsp_ready  = rr;
        #1;
        free = !r && (!m_rv || rr);
        g0   = free && q0.v && (!q1.v || m_last);
        g1   = free && q1.v && !g0;
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        if (r) begin
            sb.delete();
            m_rv = 1'b0; m_last = 1'b1; m_sat = 0; m_flag = '0;
            m_hold = '{id: 1'b0, sum: 16'h0, flag: 3'b0};
            armed = 1'b1;
        end else if (g0 || g1) begin
            e = g1 ? model_op(1'b1, q1.a, q1.b, q1.s) : model_op(1'b0, q0.a, q0.b, q0.s);
            sb.push_back(e);
            m_hold = e;
            m_rv   = 1'b1;
            m_last = g1;
            if (e.flag[1] && m_sat < SAT_MAX) m_sat++;
`ifdef ADDSUB_ARB_FLAGREG_EN
            if (g1 ? q1.w : q0.w) m_flag = e.flag;
`endif
        end else if (rr) begin
            m_rv = 1'b0;
        end
    endtask

    function automatic req_t mk(input bit v, input logic [15:0] a, input logic [15:0] b,
                                input bit s, input bit w);
        req_t q;
        q.v = v; q.a = a; q.b = b; q.s = s; q.w = w;
        return q;
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            default: return 16'($urandom());
        endcase
    endfunction

    // Monitor: compares the presented response with the scoreboard head, pops on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (rst === 1'b0 && rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: response id=%0h sum=%0h with empty scoreboard",
                             rsp_id, rsp_sum);
                end else begin
                    e = sb[0];
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_sum", 32'(rsp_sum), 32'(e.sum));
                    chk("sb_flag", 32'(rsp_flag), 32'(e.flag));
                    if (rsp_ready === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        req_t idle, q0, q1;
        idle = mk(0, 16'h0, 16'h0, 0, 0);

        // Reset with both requesters pending.
        repeat (2) cycle(1, mk(1, 16'h1111, 16'h2222, 0, 1), mk(1, 16'h3333, 16'h4444, 1, 1), 1);
        // Single add from req0, then saturating add from req1.
        cycle(0, mk(1, 16'h0003, 16'h0004, 0, 1), idle, 1);
        cycle(0, idle, mk(1, 16'h7FFF, 16'h0001, 0, 0), 1);
        cycle(0, idle, idle, 1);
        // Round-robin on sustained contention.
        repeat (4) cycle(0, mk(1, 16'h0010, 16'h0001, 0, 0), mk(1, 16'h0100, 16'h0002, 1, 0), 1);
        // Backpressure: held response blocks both requesters.
        repeat (3) cycle(0, mk(1, 16'h0020, 16'h0002, 0, 0), mk(1, 16'h0200, 16'h0003, 0, 0), 0);
        cycle(0, mk(1, 16'h0020, 16'h0002, 0, 0), mk(1, 16'h0200, 16'h0003, 0, 0), 1);
        // Zero result via subtraction, then reset with a response in flight.
        cycle(0, mk(1, 16'h1234, 16'h1234, 1, 1), idle, 1);
        cycle(0, idle, mk(1, 16'h8000, 16'h0001, 1, 0), 0);
        cycle(1, idle, idle, 0);
        cycle(0, idle, idle, 1);
        // Drive the saturation counter into its ceiling.
        repeat (300) cycle(0, mk(1, 16'h7FFF, 16'h7FFF, 0, 1), mk(1, 16'h8000, 16'h0001, 1, 0), 1);
        // Randomized traffic.
        repeat (1500) begin
            q0 = mk(($urandom_range(0, 2) != 0), rnd_op(), rnd_op(), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
            q1 = mk(($urandom_range(0, 2) != 0), rnd_op(), rnd_op(), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
            cycle(($urandom_range(0, 199) == 0), q0, q1, ($urandom_range(0, 3) != 0));
        end
        repeat (4) cycle(0, idle, idle, 1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        done = 1'b1;
        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
